// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the two-master serial bus arbiter.
//   - slave ID constants (SLV0..SLV2 legal, SLV_BAD illegal)
//   - arbiter FSM state encoding
//   - master encodings
//   - one-hot slave decode helper
package bus_pkg;

  localparam int NUM_SLAVES = 3;

  localparam logic [1:0] SLV0    = 2'd0;
  localparam logic [1:0] SLV1    = 2'd1;
  localparam logic [1:0] SLV2    = 2'd2;
  localparam logic [1:0] SLV_BAD = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    BUSY     = 2'd2
  } arb_state_t;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } master_t;

  // One-hot slave select for a slave ID; the illegal ID decodes to no slave.
  function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [1:0] id);
    logic [NUM_SLAVES-1:0] sel;
    case (id)
      SLV0:    sel = 3'b001;
      SLV1:    sel = 3'b010;
      SLV2:    sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/arb_timer.sv
// arb_timer: 8-bit saturating wait counter for the slave-ready wait.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clr         force the count to zero (wins over en)
//   en          increment the count (saturates at 255)
//   tc          count has reached TIMEOUT-1
module arb_timer
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (en && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and slave-select controller for two
// masters on the serial system bus. The grant is held for the whole
// transfer (bursts included) until the owning master drops its request.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   m1_req, m2_req           master bus requests
//   m1_slave_id, m2_slave_id target slave IDs (3 is illegal)
//   s_ready[2:0]             per-slave ready flags
//   m1_grant, m2_grant       bus ownership (never both high)
//   master_sel               mux select, 0 = master 1, 1 = master 2
//   slave_sel[2:0]           one-hot slave select, 000 without a grant
//   bus_busy                 FSM is not in IDLE
//   timeout_err              one-cycle pulse on a ready timeout abort
//   id_err                   one-cycle pulse when the chosen request has ID 3
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic [1:0] m1_slave_id,
  input  logic [1:0] m2_slave_id,
  input  logic [2:0] s_ready,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       master_sel,
  output logic [2:0] slave_sel,
  output logic       bus_busy,
  output logic       timeout_err,
  output logic       id_err
);

  arb_state_t state_q, state_d;
  master_t    last_q, last_d;
  logic       m1_grant_q, m1_grant_d;
  logic       m2_grant_q, m2_grant_d;
  logic       master_sel_q, master_sel_d;
  logic [2:0] slave_sel_q, slave_sel_d;
  logic       bus_busy_q, bus_busy_d;
  logic       timeout_err_q, timeout_err_d;
  logic       id_err_q, id_err_d;

  master_t    cand;
  logic       cand_vld;
  logic [1:0] cand_id;
  logic       gnt_req;
  logic       slv_rdy;
  logic       timer_clr;
  logic       timer_en;
  logic       timer_tc;

  // Round-robin pick: on a tie the master that did not win last time goes.
  always_comb begin
    cand_vld = m1_req | m2_req;
    cand     = M2;
    if (m1_req && m2_req) begin
      cand = (last_q == M1) ? M2 : M1;
    end else if (m1_req) begin
      cand = M1;
    end
    cand_id = (cand == M1) ? m1_slave_id : m2_slave_id;
  end

  // Request of the current owner and ready of the slave it addresses;
  // slave_sel already holds the decoded ID, so it doubles as the ready mask.
  assign gnt_req = master_sel_q ? m2_req : m1_req;
  assign slv_rdy = |(s_ready & slave_sel_q);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    m1_grant_d    = m1_grant_q;
    m2_grant_d    = m2_grant_q;
    master_sel_d  = master_sel_q;
    slave_sel_d   = slave_sel_q;
    timeout_err_d = 1'b0;
    id_err_d      = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cand_vld) begin
          // last is updated even for a bad ID so a stuck bad master
          // cannot starve the other one.
          last_d = cand;
          if (cand_id == SLV_BAD) begin
            id_err_d = 1'b1;
          end else begin
            m1_grant_d   = (cand == M1);
            m2_grant_d   = (cand == M2);
            master_sel_d = (cand == M2);
            slave_sel_d  = slave_onehot(cand_id);
            state_d      = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (!gnt_req) begin
          m1_grant_d  = 1'b0;
          m2_grant_d  = 1'b0;
          slave_sel_d = 3'b000;
          state_d     = IDLE;
        end else if (slv_rdy) begin
          state_d = BUSY;
        end else if (timer_tc) begin
          m1_grant_d    = 1'b0;
          m2_grant_d    = 1'b0;
          slave_sel_d   = 3'b000;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      BUSY: begin
        if (!gnt_req) begin
          m1_grant_d  = 1'b0;
          m2_grant_d  = 1'b0;
          slave_sel_d = 3'b000;
          state_d     = IDLE;
        end
      end
      default: begin
        m1_grant_d  = 1'b0;
        m2_grant_d  = 1'b0;
        slave_sel_d = 3'b000;
        state_d     = IDLE;
      end
    endcase

    bus_busy_d = (state_d != IDLE);
  end

  // Timer runs only while waiting and is zero on every entry to WAIT_RDY.
  assign timer_clr = (state_d != WAIT_RDY);

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .tc    (timer_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_q        <= M2;
      m1_grant_q    <= 1'b0;
      m2_grant_q    <= 1'b0;
      master_sel_q  <= 1'b0;
      slave_sel_q   <= 3'b000;
      bus_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      id_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      m1_grant_q    <= m1_grant_d;
      m2_grant_q    <= m2_grant_d;
      master_sel_q  <= master_sel_d;
      slave_sel_q   <= slave_sel_d;
      bus_busy_q    <= bus_busy_d;
      timeout_err_q <= timeout_err_d;
      id_err_q      <= id_err_d;
    end
  end

  assign m1_grant    = m1_grant_q;
  assign m2_grant    = m2_grant_q;
  assign master_sel  = master_sel_q;
  assign slave_sel   = slave_sel_q;
  assign bus_busy    = bus_busy_q;
  assign timeout_err = timeout_err_q;
  assign id_err      = id_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter. Outputs are packed into obs as
// {m1_grant, m2_grant, master_sel, slave_sel[2:0], bus_busy, timeout_err, id_err}.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       m1_req, m2_req;
  logic [1:0] m1_slave_id, m2_slave_id;
  logic [2:0] s_ready;
  logic       m1_grant, m2_grant, master_sel;
  logic [2:0] slave_sel;
  logic       bus_busy, timeout_err, id_err;
  logic [8:0] obs;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .m1_req      (m1_req),
    .m2_req      (m2_req),
    .m1_slave_id (m1_slave_id),
    .m2_slave_id (m2_slave_id),
    .s_ready     (s_ready),
    .m1_grant    (m1_grant),
    .m2_grant    (m2_grant),
    .master_sel  (master_sel),
    .slave_sel   (slave_sel),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err),
    .id_err      (id_err)
  );

  assign obs = {m1_grant, m2_grant, master_sel, slave_sel, bus_busy, timeout_err, id_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; m1_req = 0; m2_req = 0; m1_slave_id = 0; m2_slave_id = 0; s_ready = 3'b000;
    repeat (2) step();
    checks++;
    if (obs !== 9'b0_0_0_000_0_0_0) begin
      errors++; $display("FAIL reset_values got=%b exp=%b", obs, 9'b0);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    m1_req = 1; m1_slave_id = 2'd1; s_ready = 3'b111;
    step();
    checks++;
    if (obs !== 9'b1_0_0_010_1_0_0) begin
      errors++; $display("FAIL single_grant got=%b exp=%b", obs, 9'b1_0_0_010_1_0_0);
    end
    step();
    checks++;
    if (obs !== 9'b1_0_0_010_1_0_0) begin
      errors++; $display("FAIL single_busy got=%b exp=%b", obs, 9'b1_0_0_010_1_0_0);
    end
    m1_req = 0;
    step();
    checks++;
    if (obs !== 9'b0_0_0_000_0_0_0) begin
      errors++; $display("FAIL single_release got=%b exp=%b", obs, 9'b0);
    end
  endtask

  task automatic test_tie();
    apply_reset();
    m1_req = 1; m2_req = 1; m1_slave_id = 2'd0; m2_slave_id = 2'd2; s_ready = 3'b111;
    step();
    checks++;
    if (obs !== 9'b1_0_0_001_1_0_0) begin
      errors++; $display("FAIL tie_first_m1 got=%b exp=%b", obs, 9'b1_0_0_001_1_0_0);
    end
    step();
    m1_req = 0;
    step();
    checks++;
    if (obs !== 9'b0_0_0_000_0_0_0) begin
      errors++; $display("FAIL tie_m1_release got=%b exp=%b", obs, 9'b0);
    end
    step();
    checks++;
    if (obs !== 9'b0_1_1_100_1_0_0) begin
      errors++; $display("FAIL tie_m2_after_idle got=%b exp=%b", obs, 9'b0_1_1_100_1_0_0);
    end
    m2_req = 0;
    step();
    checks++;
    if (obs !== 9'b0_0_1_000_0_0_0) begin
      errors++; $display("FAIL tie_m2_release got=%b exp=%b", obs, 9'b0_0_1_000_0_0_0);
    end
    m1_req = 1; m2_req = 1;
    step();
    checks++;
    if (obs !== 9'b1_0_0_001_1_0_0) begin
      errors++; $display("FAIL tie_alternate_m1 got=%b exp=%b", obs, 9'b1_0_0_001_1_0_0);
    end
    m1_req = 0; m2_req = 0;
    step();
  endtask

  task automatic test_timeout();
    int  cnt;
    logic dropped;
    m2_req = 1; m2_slave_id = 2'd2; s_ready = 3'b011;
    step();
    cnt = m2_grant ? 1 : 0;
    dropped = 1'b0;
    for (int i = 0; i < 40 && !dropped; i++) begin
      step();
      if (m2_grant) cnt++;
      else dropped = 1'b1;
    end
    checks++;
    if (cnt != 16 || !dropped) begin
      errors++; $display("FAIL timeout_grant_len got=%0d exp=16 dropped=%0b", cnt, dropped);
    end
    checks++;
    if (obs !== 9'b0_0_1_000_0_1_0) begin
      errors++; $display("FAIL timeout_err_pulse got=%b exp=%b", obs, 9'b0_0_1_000_0_1_0);
    end
    step();
    checks++;
    if (obs !== 9'b0_1_1_100_1_0_0) begin
      errors++; $display("FAIL timeout_regrant got=%b exp=%b", obs, 9'b0_1_1_100_1_0_0);
    end
    // Dropping the request while still waiting releases with no error.
    m2_req = 0;
    step();
    checks++;
    if (obs !== 9'b0_0_1_000_0_0_0) begin
      errors++; $display("FAIL wait_release got=%b exp=%b", obs, 9'b0_0_1_000_0_0_0);
    end
  endtask

  task automatic test_bad_id();
    m1_req = 1; m1_slave_id = 2'd3; m2_req = 1; m2_slave_id = 2'd0; s_ready = 3'b111;
    step();
    checks++;
    if (obs !== 9'b0_0_1_000_0_0_1) begin
      errors++; $display("FAIL bad_id_pulse got=%b exp=%b", obs, 9'b0_0_1_000_0_0_1);
    end
    step();
    checks++;
    if (obs !== 9'b0_1_1_001_1_0_0) begin
      errors++; $display("FAIL bad_id_m2_grant got=%b exp=%b", obs, 9'b0_1_1_001_1_0_0);
    end
    m1_req = 0; m2_req = 0;
    step();
    step();
  endtask

  task automatic test_burst();
    int held;
    int both;
    m1_req = 1; m1_slave_id = 2'd0; m2_req = 1; m2_slave_id = 2'd1; s_ready = 3'b111;
    step();
    held = 0; both = 0;
    for (int i = 0; i < 300; i++) begin
      if (m1_grant === 1'b1 && m2_grant === 1'b0) held++;
      if (m1_grant === 1'b1 && m2_grant === 1'b1) both++;
      step();
    end
    checks++;
    if (held != 300) begin
      errors++; $display("FAIL burst_hold got=%0d exp=300", held);
    end
    checks++;
    if (both != 0) begin
      errors++; $display("FAIL burst_exclusive got=%0d exp=0", both);
    end
    m1_req = 0;
    step();
    checks++;
    if (obs !== 9'b0_0_0_000_0_0_0) begin
      errors++; $display("FAIL burst_release got=%b exp=%b", obs, 9'b0);
    end
    step();
    checks++;
    if (obs !== 9'b0_1_1_010_1_0_0) begin
      errors++; $display("FAIL burst_m2_next got=%b exp=%b", obs, 9'b0_1_1_010_1_0_0);
    end
  endtask

  task automatic test_reset_busy();
    step();
    reset = 1'b1;
    #2;
    checks++;
    if (obs !== 9'b0_0_0_000_0_0_0) begin
      errors++; $display("FAIL async_reset got=%b exp=%b", obs, 9'b0);
    end
    reset = 1'b0;
    step();
    checks++;
    if (obs !== 9'b0_1_1_010_1_0_0) begin
      errors++; $display("FAIL post_reset_grant got=%b exp=%b", obs, 9'b0_1_1_010_1_0_0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_bad_id();
    test_burst();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
